// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit.
// Op encodings, FSM states and the iteration count.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldivState_t;

    function automatic logic [31:0] condNeg(
        input logic [31:0] v,
        input logic        neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of shift-add multiply or restoring divide.
// Acc holds {hi, lo}: product/multiplier or remainder/quotient.
module muldiv_core #(
    parameter int W = 32
) (
    input  logic           IsDiv,
    input  logic [2*W-1:0] Acc,
    input  logic [W-1:0]   Operand,
    output logic [2*W-1:0] AccNext
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, Acc[2*W-1:W]} + {1'b0, Operand};
        diff = Acc[2*W-1:W-1] - {1'b0, Operand};
        AccNext = '0;
        if (IsDiv) begin
            // No borrow means the shifted remainder covers the divisor
            if (!diff[W])
                AccNext = {diff[W-1:0], Acc[W-2:0], 1'b1};
            else
                AccNext = {Acc[2*W-2:0], 1'b0};
        end else begin
            if (Acc[0])
                AccNext = {sum, Acc[W-1:1]};
            else
                AccNext = {1'b0, Acc[2*W-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit writing the Hi/Lo pair.
// Fixed latency: one load cycle, 32 steps, one sign-fix cycle.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              Busy,
    output logic              Done,
    output logic              WriteEn,
    output logic [DATA_W-1:0] HiOut,
    output logic [DATA_W-1:0] LoOut,
    output logic              DivByZero
);

    localparam logic [5:0] CNT_LAST = 6'(MULDIV_ITERS);

    muldivState_t state, stateNext;

    logic [5:0]          cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] accNext;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   aReg;
    logic [DATA_W-1:0]   magA;
    logic [DATA_W-1:0]   magB;
    logic                isDivReg;
    logic                bZero;
    logic                negRes;
    logic                negRem;
    logic                isSigned;

    assign isSigned = !Op[0];
    assign prod     = negRes ? -acc : acc;
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);
    assign WriteEn  = Done;

    muldiv_core #(.W(DATA_W)) u_core (
        .IsDiv   (isDivReg),
        .Acc     (acc),
        .Operand (magB),
        .AccNext (accNext)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (Start) stateNext = CALC;
            CALC:    if (cnt == CNT_LAST) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt       <= '0;
            acc       <= '0;
            aReg      <= '0;
            magA      <= '0;
            magB      <= '0;
            isDivReg  <= 1'b0;
            bZero     <= 1'b0;
            negRes    <= 1'b0;
            negRem    <= 1'b0;
            HiOut     <= '0;
            LoOut     <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    cnt      <= '0;
                    aReg     <= A;
                    magA     <= condNeg(A, isSigned && A[DATA_W-1]);
                    magB     <= condNeg(B, isSigned && B[DATA_W-1]);
                    isDivReg <= Op[1];
                    bZero    <= (B == '0);
                    negRes   <= isSigned && (A[DATA_W-1] ^ B[DATA_W-1]);
                    negRem   <= isSigned && A[DATA_W-1];
                end
                CALC: begin
                    // First CALC cycle seeds the low half; steps follow
                    if (cnt == '0) acc <= {{DATA_W{1'b0}}, magA};
                    else           acc <= accNext;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (isDivReg && bZero) begin
                        HiOut     <= aReg;
                        LoOut     <= '1;
                        DivByZero <= 1'b1;
                    end else if (isDivReg) begin
                        HiOut     <= condNeg(acc[2*DATA_W-1:DATA_W], negRem);
                        LoOut     <= condNeg(acc[DATA_W-1:0], negRes);
                        DivByZero <= 1'b0;
                    end else begin
                        HiOut     <= prod[2*DATA_W-1:DATA_W];
                        LoOut     <= prod[DATA_W-1:0];
                        DivByZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed checks for hilo_muldiv_unit results, latency,
// start filtering and reset abort.
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        WriteEn;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        DivByZero;

    int nChecks = 0;
    int nPass   = 0;

    hilo_muldiv_unit #(.DATA_W(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .WriteEn   (WriteEn),
        .HiOut     (HiOut),
        .LoOut     (LoOut),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    task automatic startOp(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 2'b00; A = 32'hDEADBEEF; B = 32'h0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 60) begin
            @(posedge Clk); #1;
            lat++;
            if (Done) break;
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic expDz);
        int lat;
        startOp(op, a, b);
        check({tag, " busy"}, 64'(Busy), 64'd1);
        waitDone(lat);
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " wen"}, 64'(WriteEn), 64'd1);
        check({tag, " hi"}, 64'(HiOut), 64'(expHi));
        check({tag, " lo"}, 64'(LoOut), 64'(expLo));
        check({tag, " dz"}, 64'(DivByZero), 64'(expDz));
        @(posedge Clk); #1;
        check({tag, " wen pulse"}, 64'(WriteEn), 64'd0);
        check({tag, " hold lo"}, 64'(LoOut), 64'(expLo));
    endtask

    initial begin
        int lat;
        int doneCnt;
        int wenCnt;
        logic [31:0] loAtDone;

        Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst busy", 64'(Busy), 64'd0);
        check("rst done", 64'(Done), 64'd0);
        check("rst wen", 64'(WriteEn), 64'd0);
        check("rst dz", 64'(DivByZero), 64'd0);
        check("rst hi", 64'(HiOut), 64'd0);
        check("rst lo", 64'(LoOut), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;

        runOp("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'd5,
              32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        runOp("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 1'b0);
        runOp("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runOp("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE,
              32'h00000001, 32'hFFFFFFFD, 1'b0);
        runOp("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 1'b0);
        runOp("divu 100/7", 2'b11, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0);
        runOp("divu 100/0", 2'b11, 32'd100, 32'd0,
              32'h00000064, 32'hFFFFFFFF, 1'b1);
        runOp("multu 2*3", 2'b01, 32'd2, 32'd3,
              32'd0, 32'd6, 1'b0);
        runOp("div -5/0", 2'b10, 32'hFFFFFFFB, 32'd0,
              32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        runOp("mult big", 2'b00, 32'h12345678, 32'h10,
              32'h00000001, 32'h23456780, 1'b0);

        // Start offered in the DONE cycle must not launch an op
        startOp(2'b01, 32'd4, 32'd4);
        waitDone(lat);
        check("done-start latency", 64'(lat), 64'd34);
        @(negedge Clk);
        Start = 1'b1; Op = 2'b01; A = 32'd5; B = 32'd5;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("done-start busy", 64'(Busy), 64'd0);
        @(posedge Clk); #1;
        check("done-start idle", 64'(Busy), 64'd0);
        check("done-start lo", 64'(LoOut), 64'd16);

        // Start re-pulsed mid-operation is dropped
        startOp(2'b01, 32'd7, 32'd9);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1; Op = 2'b01; A = 32'd1; B = 32'd1;
        @(posedge Clk); #1;
        Start = 1'b0;
        doneCnt = 0; loAtDone = '0; lat = 0;
        for (int i = 6; i <= 80; i++) begin
            @(posedge Clk); #1;
            if (Done) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    loAtDone = LoOut;
                    lat = i;
                end
            end
        end
        check("repulse dones", 64'(doneCnt), 64'd1);
        check("repulse latency", 64'(lat), 64'd34);
        check("repulse lo", 64'(loAtDone), 64'h3F);

        // Reset mid-operation aborts with no write
        startOp(2'b00, 32'd3, 32'd3);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1; Start = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; Start = 1'b0;
        check("abort busy", 64'(Busy), 64'd0);
        check("abort hi", 64'(HiOut), 64'd0);
        check("abort lo", 64'(LoOut), 64'd0);
        wenCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (WriteEn) wenCnt++;
        end
        check("abort no wen", 64'(wenCnt), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameter: DATA_W, 32, operand and Hi/Lo width; only 32 is supported.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  input  32  multiplicand or dividend (rs).
REQ-007 B  input  32  multiplier or divisor (rt).
REQ-008 Busy  output  1  operation in progress; new Start ignored.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 WriteEn  output  1  Hi/Lo register write strobe; equal to Done.
REQ-011 HiOut  output  32  product high word or remainder.
REQ-012 LoOut  output  32  product low word or quotient.
REQ-013 DivByZero  output  1  high with Done when a DIV/DIVU had B == 0.

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE.
REQ-015 Transitions: IDLE->CALC on Start; CALC->FIX after exactly 32 iterations; FIX->DONE; DONE->IDLE.
REQ-016 In IDLE with Start=1, A, B and Op are latched.
- For signed ops, operand magnitudes are latched together with the result-sign and remainder-sign bits.
REQ-017 A and B are don't-care after the Start edge.
REQ-018 Multiply uses a shift-add step per CALC cycle on a 64-bit accumulator.
REQ-019 Divide uses a restoring shift-subtract step per CALC cycle, producing one quotient bit per cycle.
REQ-020 FIX applies two's-complement negation where the sign bits require it and registers HiOut/LoOut.
REQ-021 Latency is constant for all ops and operands.
- Done and WriteEn are high in the cycle following the 34th rising edge after the Start-sampling edge.
REQ-022 Busy is high from the edge after Start is sampled through the Done cycle, inclusive.
- Busy is low in IDLE.
REQ-023 Start asserted while Busy=1 is ignored, with no queuing.
- Start asserted during the DONE cycle is ignored.
REQ-024 Signed division truncates toward zero; the remainder takes the dividend's sign.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF gives LoOut=0x80000000, HiOut=0x00000000, DivByZero=0.
REQ-026 Division with B == 0 (DIV or DIVU):
- HiOut = latched A, LoOut = 0xFFFFFFFF, DivByZero=1.
- Full latency is kept.
REQ-027 HiOut, LoOut and DivByZero hold their values from FIX until the next FIX.
- DivByZero clears on the next completed op with a nonzero divisor or on any multiply.
REQ-028 Multiply never sets DivByZero.

Reset
REQ-029 On Rst=1 at a rising edge:
- State becomes IDLE.
- Busy, Done, WriteEn and DivByZero are set to 0.
- HiOut and LoOut are set to 0x00000000.
- Internal accumulator and counter are set to 0.
REQ-030 Rst mid-operation aborts the operation; no Done/WriteEn pulse follows.
REQ-031 Rst takes priority over Start in the same cycle.

Structure
REQ-032 Shared package muldiv_pkg holds:
- Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
- The FSM state enum.
- The iteration count constant MULDIV_ITERS = 32.
REQ-033 Sub-module muldiv_core implements the per-cycle shift-add / shift-subtract step as combinational logic.
- The FSM, counter and sign handling remain in hilo_muldiv_unit.

Verification
REQ-034 MULT A=0xFFFFFFFD (-3), B=5 -> Done at +34: HiOut=0xFFFFFFFF, LoOut=0xFFFFFFF1, WriteEn=1 for one cycle.
REQ-035 MULTU A=B=0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF, DivByZero=0.
REQ-037 DIVU A=100, B=0 -> HiOut=0x00000064, LoOut=0xFFFFFFFF, DivByZero=1 at +34.
- A subsequent MULTU 2*3 returns Lo=6 and DivByZero=0.
REQ-038 Start MULTU 7*9 with Start re-pulsed at +5 (A=1, B=1):
- Exactly one Done, with LoOut=0x0000003F.
REQ-039 Start MULT, then assert Rst at +10:
- Busy=0 next cycle, HiOut=LoOut=0.
- No WriteEn within the following 40 cycles.
